unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the pipelined core.
- Only one transaction is outstanding at a time.
- Data requests take priority over fetch requests. A streak counter prevents fetch starvation.
- Fetch responses can be discarded on a pipeline flush (branch/jump redirect).

Parameters:
- XLEN, 32, width of address and data buses.
- MAX_D_STREAK, 4, number of consecutive data grants allowed while fetch is pending before fetch is forced. Must be at least 1.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request
- if_addr  in  XLEN  fetch address, word-aligned
- if_gnt  out  1  one-cycle pulse: fetch request latched
- if_rvalid  out  1  fetch data valid
- if_rdata  out  XLEN  fetch data
- d_req  in  1  data request (load or store)
- d_we  in  1  1 = store
- d_be  in  XLEN/8  byte enables
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_gnt  out  1  one-cycle pulse: data request latched
- d_rvalid  out  1  load data valid, or store acknowledge
- d_rdata  out  XLEN  load data
- flush  in  1  discard any in-flight fetch
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_be  out  XLEN/8  memory byte enables
- mem_addr  out  XLEN  memory address
- mem_wdata  out  XLEN  memory write data
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  memory response, asserted for both reads and writes
- mem_rdata  in  XLEN  memory read data

Behaviour:
- Clocking/reset: all state is on the rising edge of clk. Reset is synchronous and active-low.
- Reset values: state = IDLE; streak = 0; discard = 0. All mem_* outputs 0. if_gnt, d_gnt, if_rvalid, d_rvalid = 0.
- States: IDLE, REQ_I, WAIT_I, REQ_D, WAIT_D.
- IDLE, arbitration:
  - Data is granted if d_req, unless if_req && streak == MAX_D_STREAK && !flush.
  - Otherwise fetch is granted if if_req && !flush. flush in IDLE blocks the fetch grant that cycle.
- On a grant:
  - Pulse if_gnt or d_gnt in the same cycle, combinationally.
  - Register address, we, be and wdata. Fetch forces we = 0, be = all ones, wdata = 0.
  - Next state is REQ_I or REQ_D.
  - The requester may change or drop its request from the next cycle.
- REQ_x: mem_req = 1 with stable fields. Move to WAIT_x on mem_req && mem_gnt. A request is never withdrawn.
- WAIT_x: mem_req = 0. Return to IDLE on mem_rvalid. There is always one dead IDLE cycle between transactions.
- Responses are combinational pass-through:
  - d_rvalid = mem_rvalid && state == WAIT_D.
  - if_rvalid = mem_rvalid && state == WAIT_I && !discard && !flush.
  - d_rdata and if_rdata are driven from mem_rdata.
- Streak counter, updated on an IDLE grant only:
  - Data grant with if_req high: streak increments, saturating at MAX_D_STREAK.
  - Fetch grant, or data grant with if_req low: streak = 0.
  - Width is $clog2(MAX_D_STREAK+1).
- Flush:
  - flush in REQ_I or WAIT_I sets discard. The memory transaction still completes; its response is suppressed.
  - discard clears on return to IDLE.
  - flush in REQ_D or WAIT_D has no effect.
- mem_rvalid outside a WAIT state is ignored. An optional assertion flags it.
- Reset during any state aborts immediately to IDLE with mem_req = 0. The memory side is reset together with the arbiter.

Optional Feature:
- Macro: UNIFIED_MEM_ARB_PERF_EN.
- When defined, three extra output ports are added, all XLEN wide and wrapping: perf_if_grants, perf_d_grants, perf_stall_cycles.
  - perf_stall_cycles counts cycles where if_req is high and not granted.
  - All three are cleared by reset.
- When undefined, these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- core_pkg holds:
  - enum arb_state_e {IDLE, REQ_I, WAIT_I, REQ_D, WAIT_D}
  - XLEN default
  - constant IF_BE_ALL
- One combinational sub-module, mem_arb_pick. Inputs: if_req, d_req, flush, streak_at_max. Outputs: one-hot grant.
- The FSM, field registers and response gating stay in the top module.

Test Plan:
- Lone data load:
  - Stimulus: d_req=1, d_we=0, addr 0x100; mem_gnt on the first REQ cycle; mem_rvalid 2 cycles later with 0xDEADBEEF.
  - Response: d_gnt at cycle 0, mem_req at cycle 1, d_rvalid with 0xDEADBEEF at cycle 4, back in IDLE at cycle 5.
- Simultaneous if_req and d_req, streak = 0 → d_gnt first. Fetch is granted in the IDLE cycle after the data response.
- Starvation guard:
  - Stimulus: if_req and d_req held continuously, MAX_D_STREAK = 4, memory always 1-cycle.
  - Response: grant order D,D,D,D,I,D,D,D,D,I.
- Store with mem_gnt delayed 3 cycles → mem_req, mem_we=1, mem_be=0x3 and mem_wdata held stable for all 3 cycles. d_rvalid pulses once on mem_rvalid.
- Flush mid-fetch: flush pulsed in WAIT_I → mem_rvalid arrives, if_rvalid stays 0, FSM returns to IDLE. flush in IDLE with only if_req pending → no if_gnt that cycle.
- Reset in WAIT_D (rst_n low for one edge) → IDLE next cycle, mem_req=0, streak=0. A later mem_rvalid produces no d_rvalid.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package core_pkg;

   localparam int XLEN_DEFAULT = 32;

   // Byte-enable pattern used for fetches; sliced to XLEN/8 by the user (XLEN <= 128).
   localparam logic [15:0] IF_BE_ALL = 16'hFFFF;

   // Bit positions inside the one-hot grant vector produced by mem_arb_pick.
   localparam int GNT_I = 0;
   localparam int GNT_D = 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ_I  = 3'd1,
      WAIT_I = 3'd2,
      REQ_D  = 3'd3,
      WAIT_D = 3'd4
   } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority pick between fetch and data requests.
// Data wins unless fetch has been starved for the maximum streak; flush
// suppresses a fetch grant and also disables the starvation override.
module mem_arb_pick
   import core_pkg::*;
(
   input  logic       if_req,
   input  logic       d_req,
   input  logic       flush,
   input  logic       streak_at_max,
   output logic [1:0] gnt
);

   // One-hot grant: data first, fetch only when data is not taken.
   always_comb begin
      gnt        = 2'b00;
      gnt[GNT_D] = d_req && !(if_req && streak_at_max && !flush);
      gnt[GNT_I] = !gnt[GNT_D] && if_req && !flush;
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter shared by the IF fetch port and MEM load/store port.
// One transaction outstanding at a time; data has priority with a streak
// counter guarding fetch against starvation; flush discards in-flight fetches.
// Optional performance counters: define UNIFIED_MEM_ARB_PERF_EN.
module unified_mem_arbiter
   import core_pkg::*;
#(
   parameter int XLEN         = XLEN_DEFAULT,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [XLEN-1:0]   if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [XLEN-1:0]   if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [XLEN/8-1:0] d_be,
   input  logic [XLEN-1:0]   d_addr,
   input  logic [XLEN-1:0]   d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [XLEN-1:0]   d_rdata,
   input  logic              flush,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata
`ifdef UNIFIED_MEM_ARB_PERF_EN
   ,
   output logic [XLEN-1:0]   perf_if_grants,
   output logic [XLEN-1:0]   perf_d_grants,
   output logic [XLEN-1:0]   perf_stall_cycles
`endif
);

   localparam int BW = XLEN / 8;
   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   arb_state_e        state_q, state_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic              discard_q, discard_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic              we_q, we_d;
   logic [BW-1:0]     be_q, be_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;

   logic [1:0]        pick_gnt;
   logic              streak_at_max;

   assign streak_at_max = (streak_q == STREAK_MAX);

   mem_arb_pick u_pick (
      .if_req        (if_req),
      .d_req         (d_req),
      .flush         (flush),
      .streak_at_max (streak_at_max),
      .gnt           (pick_gnt)
   );

   // Next-state, field capture, streak and discard tracking, grant pulses.
   always_comb begin
      state_d   = state_q;
      streak_d  = streak_q;
      discard_d = discard_q;
      addr_d    = addr_q;
      we_d      = we_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      case (state_q)
         IDLE: begin
            discard_d = 1'b0;
            if (rst_n && pick_gnt[GNT_D]) begin
               d_gnt    = 1'b1;
               addr_d   = d_addr;
               we_d     = d_we;
               be_d     = d_be;
               wdata_d  = d_wdata;
               state_d  = REQ_D;
               // Streak only grows while a fetch is actually being held off.
               if (!if_req) begin
                  streak_d = '0;
               end else if (!streak_at_max) begin
                  streak_d = streak_q + 1'b1;
               end
            end else if (rst_n && pick_gnt[GNT_I]) begin
               if_gnt   = 1'b1;
               addr_d   = if_addr;
               we_d     = 1'b0;
               be_d     = IF_BE_ALL[BW-1:0];
               wdata_d  = '0;
               streak_d = '0;
               state_d  = REQ_I;
            end
         end
         REQ_I: begin
            if (flush) begin
               discard_d = 1'b1;
            end
            if (mem_gnt) begin
               state_d = WAIT_I;
            end
         end
         WAIT_I: begin
            if (mem_rvalid) begin
               state_d   = IDLE;
               discard_d = 1'b0;
            end else if (flush) begin
               discard_d = 1'b1;
            end
         end
         REQ_D: begin
            if (mem_gnt) begin
               state_d = WAIT_D;
            end
         end
         WAIT_D: begin
            if (mem_rvalid) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and captured request fields; everything clears on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         streak_q  <= '0;
         discard_q <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         streak_q  <= streak_d;
         discard_q <= discard_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
      end
   end

   // Memory side: request is a state decode, forced low while reset is held.
   assign mem_req   = rst_n && ((state_q == REQ_I) || (state_q == REQ_D));
   assign mem_we    = we_q;
   assign mem_be    = be_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   // Responses pass straight through; mem_rvalid outside a WAIT state is dropped.
   assign d_rvalid  = rst_n && mem_rvalid && (state_q == WAIT_D);
   assign if_rvalid = rst_n && mem_rvalid && (state_q == WAIT_I) && !discard_q && !flush;
   assign d_rdata   = mem_rdata;
   assign if_rdata  = mem_rdata;

`ifdef UNIFIED_MEM_ARB_PERF_EN
   logic [XLEN-1:0] perf_if_grants_q, perf_if_grants_d;
   logic [XLEN-1:0] perf_d_grants_q, perf_d_grants_d;
   logic [XLEN-1:0] perf_stall_cycles_q, perf_stall_cycles_d;

   // Wrapping event counters for grants and fetch stall cycles.
   always_comb begin
      perf_if_grants_d    = perf_if_grants_q + {{(XLEN-1){1'b0}}, if_gnt};
      perf_d_grants_d     = perf_d_grants_q + {{(XLEN-1){1'b0}}, d_gnt};
      perf_stall_cycles_d = perf_stall_cycles_q + {{(XLEN-1){1'b0}}, (if_req && !if_gnt)};
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_if_grants_q    <= '0;
         perf_d_grants_q     <= '0;
         perf_stall_cycles_q <= '0;
      end else begin
         perf_if_grants_q    <= perf_if_grants_d;
         perf_d_grants_q     <= perf_d_grants_d;
         perf_stall_cycles_q <= perf_stall_cycles_d;
      end
   end

   assign perf_if_grants    = perf_if_grants_q;
   assign perf_d_grants     = perf_d_grants_q;
   assign perf_stall_cycles = perf_stall_cycles_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: transaction-level reference
// model, end-to-end memory shadow, randomized memory responder, directed cases.
module tb_unified_mem_arbiter;

   localparam int XLEN = 32;
   localparam int MAXS = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n, if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid, flush;
   logic [31:0]     if_addr, if_rdata, d_addr, d_wdata, d_rdata;
   logic [3:0]      d_be, mem_be;
   logic            mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0]     mem_addr, mem_wdata, mem_rdata;
`ifdef UNIFIED_MEM_ARB_PERF_EN
   logic [31:0]     perf_if_grants, perf_d_grants, perf_stall_cycles;
`endif

   unified_mem_arbiter #(.XLEN(XLEN), .MAX_D_STREAK(MAXS)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef UNIFIED_MEM_ARB_PERF_EN
      , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants), .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   // Stimulus requested by the test sequence, applied just after each rising edge.
   logic        s_rst_n = 1'b0, s_if_req = 1'b0, s_d_req = 1'b0, s_d_we = 1'b0, s_flush = 1'b0;
   logic [31:0] s_if_addr = 32'h100, s_d_addr = 32'h100, s_d_wdata = 32'h0;
   logic [3:0]  s_d_be = 4'hF;
   logic        s_force_rvalid = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   // Memory contents: mem_arr is what the memory holds, shadow is what the
   // requesters expect to read back.
   logic [31:0] mem_arr [16];
   logic [31:0] shadow  [16];

   // Memory responder.
   bit          r_out = 1'b0;
   int          r_wait = 0;
   logic [31:0] r_data = 32'h0;
   int          r_gnt_pct = 100, r_lat_min = 0, r_lat_max = 0;
   bit          r_spur = 1'b0;

   // Reference model: transaction in flight, who owns it, accepted yet, discard.
   bit          m_busy = 1'b0, m_own_d = 1'b0, m_acc = 1'b0, m_disc = 1'b0;
   int          m_streak = 0;
   logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
   logic        m_we = 1'b0;
   logic [3:0]  m_be = 4'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic e_ig, e_dg, e_mr, e_ir, e_dr;
      e_ig = 1'b0; e_dg = 1'b0; e_mr = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
      if (!rst_n) begin
         e_ig = 1'b0;
      end else if (!m_busy) begin
         e_dg = d_req && !(if_req && (m_streak == MAXS) && !flush);
         e_ig = !e_dg && if_req && !flush;
      end else if (!m_acc) begin
         e_mr = 1'b1;
      end else begin
         e_dr = m_own_d && mem_rvalid;
         e_ir = !m_own_d && mem_rvalid && !m_disc && !flush;
      end
      chk("if_gnt", if_gnt, e_ig);
      chk("d_gnt", d_gnt, e_dg);
      chk("mem_req", mem_req, e_mr);
      chk("if_rvalid", if_rvalid, e_ir);
      chk("d_rvalid", d_rvalid, e_dr);
      if (e_mr) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_we", mem_we, m_we);
         chk("mem_be", mem_be, m_be);
         chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (e_dr && !m_we) chk("d_rdata", d_rdata, shadow[m_addr[5:2]]);
      if (e_ir) chk("if_rdata", if_rdata, shadow[m_addr[5:2]]);

      if (!rst_n) begin
         m_busy = 1'b0; m_streak = 0; m_disc = 1'b0;
      end else if (!m_busy) begin
         if (e_dg) begin
            m_busy = 1'b1; m_own_d = 1'b1; m_acc = 1'b0;
            m_addr = d_addr; m_we = d_we; m_be = d_be; m_wdata = d_wdata;
            m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            if (d_we) begin
               for (int b = 0; b < 4; b++)
                  if (d_be[b]) shadow[d_addr[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
            end
         end else if (e_ig) begin
            m_busy = 1'b1; m_own_d = 1'b0; m_acc = 1'b0; m_disc = 1'b0;
            m_addr = if_addr; m_we = 1'b0; m_be = 4'hF; m_wdata = 32'h0;
            m_streak = 0;
         end
      end else if (!m_acc) begin
         if (!m_own_d && flush) m_disc = 1'b1;
         if (mem_gnt) m_acc = 1'b1;
      end else begin
         if (mem_rvalid) begin
            m_busy = 1'b0; m_disc = 1'b0;
         end else if (!m_own_d && flush) begin
            m_disc = 1'b1;
         end
      end
   endtask

   task automatic resp_update();
      if (!rst_n) begin
         r_out = 1'b0;
      end else begin
         if (mem_rvalid && r_out) r_out = 1'b0;
         if (mem_req && mem_gnt) begin
            r_out  = 1'b1;
            r_wait = $urandom_range(r_lat_max, r_lat_min);
            r_data = mem_arr[mem_addr[5:2]];
            if (mem_we) begin
               for (int b = 0; b < 4; b++)
                  if (mem_be[b]) mem_arr[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      rst_n = s_rst_n; if_req = s_if_req; if_addr = s_if_addr;
      d_req = s_d_req; d_we = s_d_we; d_be = s_d_be; d_addr = s_d_addr; d_wdata = s_d_wdata;
      flush = s_flush;
      mem_gnt = ($urandom_range(99, 0) < r_gnt_pct);
      mem_rdata = $urandom;
      if (s_force_rvalid) begin
         mem_rvalid = 1'b1;
      end else if (r_out) begin
         if (r_wait == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = r_data;
         end else begin
            mem_rvalid = 1'b0;
            r_wait--;
         end
      end else begin
         mem_rvalid = r_spur && ($urandom_range(9, 0) == 0);
      end
      @(negedge clk);
      model_step();
      resp_update();
   endtask

   task automatic drain();
      s_if_req = 1'b0; s_d_req = 1'b0; s_flush = 1'b0;
      for (int i = 0; i < 60 && m_busy; i++) cycle();
      chk("drain_idle", {31'b0, m_busy}, 32'h0);
   endtask

   task automatic collect(input int n, output logic [15:0] pat);
      int got;
      got = 0;
      pat = 16'h0;
      for (int i = 0; i < n * 6 + 10 && got < n; i++) begin
         cycle();
         if (d_gnt) begin
            pat = {pat[14:0], 1'b1}; got++;
         end else if (if_gnt) begin
            pat = {pat[14:0], 1'b0}; got++;
         end
      end
      chk("collect_count", got, n);
   endtask

   task automatic rand_stim();
      s_if_req  = ($urandom_range(99, 0) < 60);
      s_if_addr = 32'h100 + 32'($urandom_range(15, 0)) * 4;
      s_d_req   = ($urandom_range(99, 0) < 50);
      s_d_we    = ($urandom_range(1, 0) == 1);
      s_d_be    = 4'($urandom_range(15, 0));
      s_d_addr  = 32'h100 + 32'($urandom_range(15, 0)) * 4;
      s_d_wdata = $urandom;
      s_flush   = ($urandom_range(99, 0) < 10);
   endtask

   initial begin
      logic [15:0] pat;
      int pulses;
      rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; flush = 1'b0; d_we = 1'b0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      for (int i = 0; i < 16; i++) begin
         mem_arr[i] = $urandom;
         shadow[i]  = mem_arr[i];
      end
      mem_arr[0] = 32'hDEADBEEF;
      shadow[0]  = 32'hDEADBEEF;

      // Reset state.
      cycle(); cycle();
      s_rst_n = 1'b1;
      cycle();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);

      // Lone data load at 0x100, accepted at once, answered two cycles later.
      r_gnt_pct = 100; r_lat_min = 2; r_lat_max = 2;
      s_d_req = 1'b1; s_d_we = 1'b0; s_d_addr = 32'h100; s_d_be = 4'hF;
      cycle();
      chk("load_c0_dgnt", d_gnt, 1);
      s_d_req = 1'b0;
      cycle();
      chk("load_c1_memreq", mem_req, 1);
      chk("load_c1_addr", mem_addr, 32'h100);
      cycle(); cycle();
      chk("load_c3_norvalid", d_rvalid, 0);
      cycle();
      chk("load_c4_rvalid", d_rvalid, 1);
      chk("load_c4_rdata", d_rdata, 32'hDEADBEEF);
      s_if_req = 1'b1; s_if_addr = 32'h104;
      cycle();
      chk("load_c5_idle_gnt", if_gnt, 1);
      drain();

      // Simultaneous requests with streak 0: data first, fetch right after.
      r_lat_min = 0; r_lat_max = 0;
      s_if_req = 1'b1; s_d_req = 1'b1; s_d_addr = 32'h108;
      cycle();
      chk("simul_dgnt", d_gnt, 1);
      chk("simul_no_igbt", if_gnt, 0);
      s_d_req = 1'b0;
      cycle(); cycle(); cycle();
      chk("simul_fetch_after", if_gnt, 1);
      drain();

      // Starvation guard with both requests held.
      s_if_req = 1'b1; s_d_req = 1'b1;
      collect(10, pat);
      chk("starve_order", {22'h0, pat[9:0]}, {22'h0, 10'b1111011110});
      drain();

      // Store with acceptance delayed three cycles.
      r_gnt_pct = 0; r_lat_min = 1; r_lat_max = 1;
      s_d_req = 1'b1; s_d_we = 1'b1; s_d_be = 4'h3; s_d_addr = 32'h10C; s_d_wdata = 32'hA5A51234;
      cycle();
      chk("store_dgnt", d_gnt, 1);
      s_d_req = 1'b0; s_d_wdata = 32'h0BADF00D; s_d_be = 4'hC;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("store_hold_req", mem_req, 1);
         chk("store_hold_we", mem_we, 1);
         chk("store_hold_be", mem_be, 4'h3);
         chk("store_hold_wdata", mem_wdata, 32'hA5A51234);
      end
      r_gnt_pct = 100;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         pulses += int'(d_rvalid);
      end
      chk("store_one_ack", pulses, 1);
      drain();

      // Flush during WAIT_I, then flush in IDLE blocking a fetch grant.
      r_lat_min = 2; r_lat_max = 2;
      s_d_we = 1'b0; s_d_be = 4'hF;
      s_if_req = 1'b1; s_if_addr = 32'h110;
      cycle();
      chk("flush_igbt", if_gnt, 1);
      s_if_req = 1'b0;
      cycle();
      s_flush = 1'b1;
      cycle();
      s_flush = 1'b0;
      cycle(); cycle();
      chk("flush_suppressed", if_rvalid, 0);
      s_if_req = 1'b1; s_flush = 1'b1;
      cycle();
      chk("flush_idle_no_gnt", if_gnt, 0);
      chk("flush_idle_no_req", mem_req, 0);
      s_flush = 1'b0;
      cycle();
      chk("flush_idle_then_gnt", if_gnt, 1);
      drain();

      // Reset while in WAIT_D after building a streak of three.
      r_lat_min = 3; r_lat_max = 3;
      s_if_req = 1'b1; s_d_req = 1'b1; s_d_addr = 32'h114;
      collect(3, pat);
      chk("rst_pre_streak", {29'h0, pat[2:0]}, 32'h7);
      s_if_req = 1'b0; s_d_req = 1'b0;
      cycle(); cycle();
      s_rst_n = 1'b0;
      cycle();
      s_rst_n = 1'b1; s_force_rvalid = 1'b1;
      cycle();
      chk("rst_wait_no_rvalid", d_rvalid, 0);
      chk("rst_wait_no_req", mem_req, 0);
      s_force_rvalid = 1'b0;
      r_lat_min = 0; r_lat_max = 0;
      s_if_req = 1'b1; s_d_req = 1'b1;
      collect(5, pat);
      chk("rst_streak_cleared", {27'h0, pat[4:0]}, {27'h0, 5'b11110});
      drain();

      // Randomized traffic against the model.
      r_spur = 1'b1; r_gnt_pct = 60; r_lat_min = 0; r_lat_max = 3;
      for (int i = 0; i < 4000; i++) begin
         rand_stim();
         s_rst_n = !(!m_busy && ($urandom_range(299, 0) == 0));
         cycle();
      end
      s_rst_n = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
